// File: rtl/register_scoreboard.sv
// RAW-hazard scoreboard beside decode: tracks in-flight register writes and tells decode to stall.
// Define SCOREBOARD_FWD_EN for forwarding mode (load-use stall, fwd_stage driven); else interlock.
module register_scoreboard #(
  parameter int unsigned REG_W        = 5,
  parameter int unsigned DEPTH        = 3,
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned FLUSH_STAGES = 2,
  parameter int unsigned CNT_W        = 16,
  localparam int unsigned FW          = $clog2(DEPTH + 1)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     advance,
  input  logic                     flush,
  input  logic                     issue_valid,
  input  logic                     issue_wen,
  input  logic [REG_W-1:0]         issue_wsel,
  input  logic                     issue_load,
  input  logic [NUM_SRC*REG_W-1:0] src_sel,
  input  logic [NUM_SRC-1:0]       src_used,
  output logic                     stall,
  output logic [NUM_SRC*FW-1:0]    fwd_stage,
  output logic [FW-1:0]            pending_cnt,
  output logic [CNT_W-1:0]         stall_cnt
);

  logic [DEPTH-1:0] r_valid;
  logic [REG_W-1:0] r_wsel [DEPTH];
  logic [CNT_W-1:0] r_stall_cnt;

  logic [DEPTH-1:0] w_valid_d;
  logic [REG_W-1:0] w_wsel_d [DEPTH];
  logic [DEPTH-1:0] w_match [NUM_SRC];
  logic             w_issue_ok;
  logic [FW-1:0]    w_pending;

  // Per-operand, per-entry match; a zero source never matches.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      w_match[i] = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (src_used[i] && r_valid[k] && (src_sel[i*REG_W +: REG_W] != '0) &&
            (r_wsel[k] == src_sel[i*REG_W +: REG_W])) begin
          w_match[i][k] = 1'b1;
        end
      end
    end
  end

`ifdef SCOREBOARD_FWD_EN
  logic [DEPTH-1:0] r_load;
  logic [DEPTH-1:0] w_load_d;
  logic [NUM_SRC-1:0] w_hit;
  logic [FW-1:0]    w_idx [NUM_SRC];

  // Scan oldest to youngest so the lowest matching entry wins.
  always_comb begin
    w_hit = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      w_idx[i] = '0;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (w_match[i][k]) begin
          w_hit[i] = 1'b1;
          w_idx[i] = FW'(k);
        end
      end
    end
  end

  always_comb begin
    stall     = 1'b0;
    fwd_stage = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (w_hit[i]) begin
        fwd_stage[i*FW +: FW] = w_idx[i] + FW'(1);
        if ((w_idx[i] == '0) && r_load[0]) begin
          stall = 1'b1;
        end
      end
    end
  end
`else
  logic w_unused_load;
  assign w_unused_load = issue_load;

  always_comb begin
    stall = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      stall = stall | (|w_match[i]);
    end
  end

  assign fwd_stage = '0;
`endif

  // Only real register writes occupy an entry; a stalled or flushed issue becomes a bubble.
  assign w_issue_ok = issue_valid && issue_wen && (issue_wsel != '0) && !stall && !flush;

  always_comb begin
    w_valid_d = r_valid;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_wsel_d[k] = r_wsel[k];
    end
`ifdef SCOREBOARD_FWD_EN
    w_load_d = r_load;
`endif
    if (advance) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        w_valid_d[k] = r_valid[k-1];
        w_wsel_d[k]  = r_wsel[k-1];
      end
      w_valid_d[0] = w_issue_ok;
      w_wsel_d[0]  = issue_wsel;
`ifdef SCOREBOARD_FWD_EN
      for (int unsigned k = 1; k < DEPTH; k++) begin
        w_load_d[k] = r_load[k-1];
      end
      w_load_d[0] = issue_load;
`endif
    end
    // Clearing is applied after the shift.
    if (flush) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (k < FLUSH_STAGES) begin
          w_valid_d[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_wsel[k] <= '0;
      end
`ifdef SCOREBOARD_FWD_EN
      r_load <= '0;
`endif
    end else begin
      r_valid <= w_valid_d;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_wsel[k] <= w_wsel_d[k];
      end
`ifdef SCOREBOARD_FWD_EN
      r_load <= w_load_d;
`endif
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt <= '0;
    end else if (stall && advance && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    w_pending = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_pending = w_pending + FW'(r_valid[k]);
    end
  end

  assign pending_cnt = w_pending;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_register_scoreboard.sv
// Scoreboard bench for register_scoreboard: stimulus pushes expected outputs, a negedge monitor
// pops and compares. Expectations follow SCOREBOARD_FWD_EN when it is defined.
module tb_register_scoreboard;

`ifdef SCOREBOARD_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  typedef struct packed {
    logic        st;
    logic [3:0]  fwd;
    logic [1:0]  pend;
    logic [15:0] cnt;
    logic [2:0]  sat;
  } exp_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        advance, flush, issue_valid, issue_wen, issue_load;
  logic [4:0]  issue_wsel;
  logic [9:0]  src_sel;
  logic [1:0]  src_used;
  logic        stall, s_stall;
  logic [3:0]  fwd_stage, s_fwd_stage;
  logic [1:0]  pending_cnt, s_pending_cnt;
  logic [15:0] stall_cnt;
  logic [2:0]  s_stall_cnt;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    base;

  always #5 CLK = ~CLK;

  register_scoreboard dut (
    .CLK(CLK), .nRST(nRST), .advance(advance), .flush(flush), .issue_valid(issue_valid),
    .issue_wen(issue_wen), .issue_wsel(issue_wsel), .issue_load(issue_load),
    .src_sel(src_sel), .src_used(src_used), .stall(stall), .fwd_stage(fwd_stage),
    .pending_cnt(pending_cnt), .stall_cnt(stall_cnt)
  );

  register_scoreboard #(.CNT_W(3)) dut_sat (
    .CLK(CLK), .nRST(nRST), .advance(advance), .flush(flush), .issue_valid(issue_valid),
    .issue_wen(issue_wen), .issue_wsel(issue_wsel), .issue_load(issue_load),
    .src_sel(src_sel), .src_used(src_used), .stall(s_stall), .fwd_stage(s_fwd_stage),
    .pending_cnt(s_pending_cnt), .stall_cnt(s_stall_cnt)
  );

  task automatic cmp(input string n, input string f, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s.%s: got %0d required %0d", n, f, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      cmp(n, "stall", int'(stall), int'(e.st));
      cmp(n, "fwd_stage", int'(fwd_stage), int'(e.fwd));
      cmp(n, "pending_cnt", int'(pending_cnt), int'(e.pend));
      cmp(n, "stall_cnt", int'(stall_cnt), int'(e.cnt));
      cmp(n, "sat_stall_cnt", int'(s_stall_cnt), int'(e.sat));
    end
  end

  task automatic chk(input string n, input bit st, input logic [3:0] fw, input int pend,
                     input int cnt);
    exp_t e;
    e.st   = st;
    e.fwd  = fw;
    e.pend = 2'(pend);
    e.cnt  = 16'(cnt);
    e.sat  = (cnt > 7) ? 3'd7 : 3'(cnt);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // One cycle: wait past the edge, then drive this cycle's decode inputs.
  task automatic cyc(input bit adv, input bit fl, input bit iv, input bit wen,
                     input logic [4:0] ws, input bit ld, input logic [4:0] s0,
                     input logic [4:0] s1, input logic [1:0] used);
    @(posedge CLK);
    #1;
    advance     = adv;
    flush       = fl;
    issue_valid = iv;
    issue_wen   = wen;
    issue_wsel  = ws;
    issue_load  = ld;
    src_sel     = {s1, s0};
    src_used    = used;
  endtask

  initial begin
    nRST = 1'b0;
    cyc(0, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 2'b00);

    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      advance     = 1'($urandom);
      flush       = 1'($urandom);
      issue_valid = 1'($urandom);
      issue_wen   = 1'($urandom);
      issue_wsel  = 5'($urandom);
      issue_load  = 1'($urandom);
      src_sel     = 10'($urandom);
      src_used    = 2'($urandom);
      chk("reset", 0, 4'd0, 0, 0);
    end
    cyc(1, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 2'b00);
    nRST = 1'b1;
    chk("post_reset", 0, 4'd0, 0, 0);

`ifdef SCOREBOARD_FWD_EN
    cyc(1, 0, 1, 1, 5'd5, 0, 5'd0, 5'd0, 2'b00); chk("fw_issue", 0, 4'b0000, 0, 0);
    cyc(1, 0, 1, 0, 5'd0, 0, 5'd5, 5'd0, 2'b01); chk("fw_alu_ex", 0, 4'b0001, 1, 0);
    cyc(1, 0, 0, 0, 5'd0, 0, 5'd0, 5'd5, 2'b10); chk("fw_alu_mem", 0, 4'b1000, 1, 0);
    cyc(1, 0, 1, 1, 5'd8, 1, 5'd0, 5'd0, 2'b00); chk("fw_ld_issue", 0, 4'b0000, 1, 0);
    cyc(1, 0, 1, 0, 5'd0, 0, 5'd8, 5'd0, 2'b01); chk("fw_ld_use", 1, 4'b0001, 1, 0);
    cyc(1, 0, 1, 0, 5'd0, 0, 5'd8, 5'd0, 2'b01); chk("fw_ld_fwd", 0, 4'b0010, 1, 1);
    cyc(1, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 2'b00); chk("fw_drain", 0, 4'b0000, 1, 1);
    base = 1;
`else
    cyc(1, 0, 1, 1, 5'd5, 0, 5'd0, 5'd0, 2'b00); chk("il_issue", 0, 4'd0, 0, 0);
    cyc(1, 0, 1, 0, 5'd0, 0, 5'd5, 5'd0, 2'b01); chk("il_stall1", 1, 4'd0, 1, 0);
    cyc(1, 0, 1, 0, 5'd0, 0, 5'd5, 5'd0, 2'b01); chk("il_stall2", 1, 4'd0, 1, 1);
    cyc(1, 0, 1, 0, 5'd0, 0, 5'd5, 5'd0, 2'b01); chk("il_stall3", 1, 4'd0, 1, 2);
    cyc(1, 0, 1, 0, 5'd0, 0, 5'd5, 5'd0, 2'b01); chk("il_release", 0, 4'd0, 0, 3);
    base = 3;
`endif

    // Youngest-wins and register zero.
    cyc(1, 0, 1, 1, 5'd3, 0, 5'd0, 5'd0, 2'b00); chk("yw_w1", 0, 4'd0, 0, base);
    cyc(1, 0, 1, 1, 5'd3, 0, 5'd0, 5'd0, 2'b00); chk("yw_w2", 0, 4'd0, 1, base);
    cyc(0, 0, 0, 0, 5'd0, 0, 5'd3, 5'd0, 2'b01);
    chk("yw_young", !Fwd, Fwd ? 4'b0001 : 4'b0000, 2, base);
    cyc(1, 0, 1, 1, 5'd0, 0, 5'd0, 5'd0, 2'b00); chk("yw_zero_w", 0, 4'd0, 2, base);
    cyc(0, 0, 0, 0, 5'd0, 0, 5'd0, 5'd3, 2'b10);
    chk("yw_zero_chk", !Fwd, Fwd ? 4'b1000 : 4'b0000, 2, base);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 2'b00);

    // Flush with and without advance.
    cyc(1, 0, 1, 1, 5'd1, 0, 5'd0, 5'd0, 2'b00); chk("fl_w1", 0, 4'd0, 0, base);
    cyc(1, 0, 1, 1, 5'd2, 0, 5'd0, 5'd0, 2'b00); chk("fl_w2", 0, 4'd0, 1, base);
    cyc(1, 0, 1, 1, 5'd4, 0, 5'd0, 5'd0, 2'b00); chk("fl_w3", 0, 4'd0, 2, base);
    cyc(1, 1, 1, 1, 5'd7, 0, 5'd0, 5'd0, 2'b00); chk("fl_flush", 0, 4'd0, 3, base);
    cyc(0, 0, 0, 0, 5'd0, 0, 5'd2, 5'd4, 2'b11);
    chk("fl_survivor", !Fwd, Fwd ? 4'b0011 : 4'b0000, 1, base);
    cyc(1, 0, 1, 1, 5'd6, 0, 5'd0, 5'd0, 2'b00); chk("fl_w6", 0, 4'd0, 1, base);
    cyc(0, 1, 0, 0, 5'd0, 0, 5'd6, 5'd0, 2'b01);
    chk("fl_noadv", !Fwd, Fwd ? 4'b0001 : 4'b0000, 1, base);
    cyc(1, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 2'b00); chk("fl_cleared", 0, 4'd0, 0, base);

    // Reset asserted mid-operation, between edges.
    cyc(1, 0, 1, 1, 5'd9, 0, 5'd0, 5'd0, 2'b00); chk("mr_issue", 0, 4'd0, 0, base);
    cyc(0, 0, 0, 0, 5'd0, 0, 5'd9, 5'd0, 2'b01);
    chk("mr_busy", !Fwd, Fwd ? 4'b0001 : 4'b0000, 1, base);
    cyc(1, 0, 0, 0, 5'd0, 0, 5'd9, 5'd0, 2'b01);
    nRST = 1'b0;
    chk("mr_reset", 0, 4'd0, 0, 0);
    cyc(1, 0, 0, 0, 5'd0, 0, 5'd9, 5'd0, 2'b01);
    nRST = 1'b1;
    chk("mr_release", 0, 4'd0, 0, 0);

    // Self-dependent load stream keeps stalling; the 3-bit instance must saturate at 7.
    cyc(1, 0, 1, 1, 5'd5, 1, 5'd0, 5'd0, 2'b00); chk("sat_prod", 0, 4'd0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, 1, 1, 5'd5, 1, 5'd5, 5'd0, 2'b01);
      if (i == 1) chk("sat_first", 1, Fwd ? 4'b0001 : 4'b0000, 1, 0);
    end
    cyc(0, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 2'b00);
    chk("sat_end", 0, 4'd0, Fwd ? 2 : 1, Fwd ? 8 : 12);

    @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
